// File: rtl/led_serial_rx.sv
// Serial-to-parallel LED display receiver.
// Synchronizes a slow SPI-like link and loads a display register per frame.
module led_serial_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  SysClk,
    input  logic                  SysRst,
    input  logic                  SCLK,
    input  logic                  DINex,
    input  logic                  CSIn,
    input  logic                  CLRIn,
    output logic [DATA_WIDTH-1:0] LedOut,
    output logic                  DataValid,
    output logic                  FrameErr,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH + 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync, din_sync, cs_sync, clr_sync;
    logic [SYNC_STAGES-1:0]  rdy_sync;
    logic                    sclk_d, cs_d, armed;
    logic                    sclk_s, din_s, cs_s, clr_s, rdy;
    logic                    sclk_rise, cs_rise, cs_fall;
    logic [DATA_WIDTH-1:0]   shreg, shreg_d;
    logic [DATA_WIDTH-1:0]   led_d;
    logic [CW-1:0]           cnt, cnt_d;
    logic                    dv_d, fe_d;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign din_s  = din_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign clr_s  = clr_sync[SYNC_STAGES-1];
    assign rdy    = rdy_sync[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    // A fall only counts once CSIn has truly been seen high after reset,
    // so the synchronizer's reset level cannot fake a frame start.
    assign cs_fall   = ~cs_s & cs_d & armed;

    assign Busy = (state_q == SHIFT);

    // Input synchronizers, edge-detect history and post-reset arming.
    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            sclk_sync <= '0;
            din_sync  <= '0;
            cs_sync   <= '1;
            clr_sync  <= '1;
            rdy_sync  <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], DINex};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CSIn};
            clr_sync  <= {clr_sync[SYNC_STAGES-2:0], CLRIn};
            rdy_sync  <= {rdy_sync[SYNC_STAGES-2:0], 1'b1};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            if (rdy && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    // State, shift register, counter and registered output pulses.
    always_ff @(posedge SysClk or negedge SysRst) begin
        if (!SysRst) begin
            state_q   <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            LedOut    <= '0;
            DataValid <= 1'b0;
            FrameErr  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg     <= shreg_d;
            cnt       <= cnt_d;
            LedOut    <= led_d;
            DataValid <= dv_d;
            FrameErr  <= fe_d;
        end
    end

    // Next-state: clear wins, else frame start, shift and frame end.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg;
        cnt_d   = cnt;
        led_d   = LedOut;
        dv_d    = 1'b0;
        fe_d    = 1'b0;
        if (!clr_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            led_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = SHIFT;
                        shreg_d = '0;
                        cnt_d   = '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_d = IDLE;
                        if (cnt == CW'(DATA_WIDTH)) begin
                            led_d = shreg;
                            dv_d  = 1'b1;
                        end else begin
                            fe_d = 1'b1;
                        end
                    end else if (sclk_rise) begin
                        shreg_d = {shreg[DATA_WIDTH-2:0], din_s};
                        if (cnt != CW'(DATA_WIDTH + 1)) begin
                            cnt_d = cnt + CW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_serial_rx.sv
// Scoreboard bench for led_serial_rx: stimulus queues expected frame-end
// pulses, a monitor pops and compares them whenever a pulse appears.
module tb_led_serial_rx;

    logic       SysClk = 1'b0;
    logic       SysRst = 1'b0;
    logic       SCLK   = 1'b0;
    logic       DINex  = 1'b0;
    logic       CSIn   = 1'b1;
    logic       CLRIn  = 1'b1;
    logic [7:0] LedOut;
    logic       DataValid;
    logic       FrameErr;
    logic       Busy;

    typedef struct {
        bit         err;
        logic [7:0] led;
    } exp_t;

    exp_t       q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_led = 8'h00;

    led_serial_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .SysClk   (SysClk),
        .SysRst   (SysRst),
        .SCLK     (SCLK),
        .DINex    (DINex),
        .CSIn     (CSIn),
        .CLRIn    (CLRIn),
        .LedOut   (LedOut),
        .DataValid(DataValid),
        .FrameErr (FrameErr),
        .Busy     (Busy)
    );

    always #10 SysClk = ~SysClk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge SysClk);
    endtask

    task automatic send_bits(input logic [15:0] d, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            DINex = d[i];
            cyc(4);
            SCLK = 1'b1;
            cyc(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic push_exp(input int n, input logic [15:0] d);
        exp_t e;
        if (n == 8) begin
            model_led = d[7:0];
            e.err = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        e.led = model_led;
        q.push_back(e);
    endtask

    task automatic frame(input logic [15:0] d, input int n);
        CSIn = 1'b0;
        cyc(4);
        send_bits(d, n);
        cyc(4);
        chk("busy_in_frame", 16'(Busy), 16'h1);
        push_exp(n, d);
        CSIn = 1'b1;
        cyc(8);
        chk("busy_after_frame", 16'(Busy), 16'h0);
    endtask

    // Monitor: every frame-end pulse must match the head of the queue.
    always @(negedge SysClk) begin
        if (DataValid && FrameErr) begin
            n_cmp++;
            n_bad++;
            $display("FAIL both_pulses: dv=%b fe=%b", DataValid, FrameErr);
        end else if (DataValid || FrameErr) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_pulse: dv=%b fe=%b led=%h",
                         DataValid, FrameErr, LedOut);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (FrameErr !== e.err || LedOut !== e.led) begin
                    n_bad++;
                    $display("FAIL pulse: got fe=%b led=%h want fe=%b led=%h",
                             FrameErr, LedOut, e.err, e.led);
                end
            end
        end
    end

    initial begin
        cyc(3);
        #1;
        chk("rst_led", 16'(LedOut), 16'h0);
        chk("rst_dv", 16'(DataValid), 16'h0);
        chk("rst_fe", 16'(FrameErr), 16'h0);
        chk("rst_busy", 16'(Busy), 16'h0);
        @(negedge SysClk);
        SysRst = 1'b1;
        cyc(6);

        frame(16'h00C3, 8);
        chk("led_c3", 16'(LedOut), 16'h00C3);

        // Second frame with exact load-edge timing.
        CSIn = 1'b0;
        cyc(4);
        send_bits(16'h0035, 8);
        cyc(4);
        push_exp(8, 16'h0035);
        CSIn = 1'b1;
        @(posedge SysClk);
        @(negedge SysClk);
        chk("led_hold_e1", 16'(LedOut), 16'h00C3);
        @(posedge SysClk);
        @(negedge SysClk);
        chk("led_hold_e2", 16'(LedOut), 16'h00C3);
        @(posedge SysClk);
        @(negedge SysClk);
        chk("led_load_e3", 16'(LedOut), 16'h0035);
        cyc(8);

        frame(16'h005A, 7);
        frame(16'h01A5, 9);
        chk("led_after_err", 16'(LedOut), 16'h0035);

        // SCLK activity with CSIn high is ignored.
        DINex = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(4);
            SCLK = 1'b1;
            chk("idle_busy", 16'(Busy), 16'h0);
            cyc(4);
            SCLK = 1'b0;
        end
        cyc(6);
        chk("idle_led", 16'(LedOut), 16'h0035);

        // Clear mid-frame, then finish the frame with CSIn still low.
        CSIn = 1'b0;
        cyc(4);
        send_bits(16'h000A, 4);
        CLRIn = 1'b0;
        cyc(4);
        chk("clr_led", 16'(LedOut), 16'h0);
        chk("clr_busy", 16'(Busy), 16'h0);
        model_led = 8'h00;
        CLRIn = 1'b1;
        cyc(4);
        send_bits(16'h0005, 4);
        cyc(4);
        chk("clr_no_restart", 16'(Busy), 16'h0);
        CSIn = 1'b1;
        cyc(8);
        chk("clr_led_hold", 16'(LedOut), 16'h0);

        // Reset mid-frame, then finish the partial frame.
        frame(16'h00C3, 8);
        CSIn = 1'b0;
        cyc(4);
        send_bits(16'h0012, 5);
        SysRst = 1'b0;
        #1;
        chk("rst_mid_led", 16'(LedOut), 16'h0);
        chk("rst_mid_busy", 16'(Busy), 16'h0);
        model_led = 8'h00;
        cyc(2);
        SysRst = 1'b1;
        cyc(1);
        send_bits(16'h0006, 3);
        cyc(4);
        chk("rst_no_restart", 16'(Busy), 16'h0);
        CSIn = 1'b1;
        cyc(8);
        chk("rst_led_hold", 16'(LedOut), 16'h0);

        frame(16'h0096, 8);
        chk("led_96", 16'(LedOut), 16'h0096);
        cyc(10);
        chk("queue_empty", 16'(q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_serial_rx.md
LED_SERIAL_RX -- requirements
Module: led_serial_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, bits per frame and width of LedOut.
REQ-002 Parameter: SYNC_STAGES, 2, flip-flop stages on each asynchronous input; legal range 2..3.
REQ-003 SysClk  input  1  system clock, 50 MHz; all state changes on its rising edge.
REQ-004 SysRst  input  1  asynchronous, active-low reset.
REQ-005 SCLK  input  1  serial clock from the driver; idles low; asynchronous to SysClk.
REQ-006 DINex  input  1  serial data, MSB first, valid on the SCLK rising edge.
REQ-007 CSIn  input  1  active-low chip select framing one transfer.
REQ-008 CLRIn  input  1  active-low clear of the display register.
REQ-009 LedOut  output  DATA_WIDTH  display register (parallel LED drive).
REQ-010 DataValid  output  1  one-cycle pulse when LedOut is loaded from a good frame.
REQ-011 FrameErr  output  1  one-cycle pulse when a frame ends with a wrong bit count.
REQ-012 Busy  output  1  high while a frame is in progress (state SHIFT).

Function
REQ-013 SCLK, DINex, CSIn and CLRIn shall each pass through a SYNC_STAGES-deep synchronizer before any use; the synchronizers for SCLK and CSIn shall feed a one-flop edge detector.
REQ-014 SCLK high and low times of at least 3 SysClk periods each shall be supported; faster SCLK is outside the contract.
REQ-015 The state machine shall have two states: IDLE and SHIFT.
REQ-016 IDLE -> SHIFT on the synchronized CSIn falling edge; the shift register and the bit counter shall be cleared on entry.
REQ-017 In SHIFT, each synchronized SCLK rising edge shall shift the synchronized DINex into the LSB (MSB-first assembly) and increment the bit counter.
REQ-018 The bit counter shall saturate at DATA_WIDTH+1; shifting shall continue, so the register holds the last DATA_WIDTH bits.
REQ-019 SHIFT -> IDLE on the synchronized CSIn rising edge; in that same cycle, count == DATA_WIDTH shall load LedOut from the shift register and pulse DataValid; any other count shall pulse FrameErr and leave LedOut unchanged.
REQ-020 LedOut shall update on the SysClk edge SYNC_STAGES+1 edges after the first edge that samples CSIn high at the pin.
REQ-021 An SCLK rising edge in the same cycle as the CSIn rising edge shall be ignored (not counted).
REQ-022 SCLK edges while in IDLE shall have no effect.
REQ-023 A synchronized CLRIn low shall clear LedOut to 0 on the next edge, abort any frame (state to IDLE, counter cleared), and suppress DataValid and FrameErr; it shall remain in force while CLRIn stays low.
REQ-024 CLRIn shall take priority over frame completion in the same cycle.
REQ-025 After CLRIn deasserts while CSIn is already low, no frame shall start until CSIn is seen high and then falls again.
REQ-026 DataValid and FrameErr shall never be high in the same cycle, and each shall be high for exactly one SysClk cycle per frame end.
REQ-027 Busy shall be high exactly when the state is SHIFT.

Reset
REQ-028 SysRst low shall asynchronously force: state IDLE, LedOut = 0, DataValid = 0, FrameErr = 0, Busy = 0, counter = 0, and all synchronizer flops to their idle levels (SCLK 0, CSIn 1, CLRIn 1, DINex 0).
REQ-029 Reset deassertion mid-frame shall leave the block in IDLE until a fresh CSIn falling edge occurs; a partial frame shall produce no pulse.

Verification
REQ-030 CSIn low, 8 SCLK pulses carrying 0xC3, CSIn high -> LedOut = 0xC3, one DataValid pulse, FrameErr stays 0, Busy low after the frame ends.
REQ-031 A second frame carrying 0x35 -> LedOut changes 0xC3 -> 0x35 at the edge given by REQ-020 and at no other time.
REQ-032 A 7-bit frame, then a 9-bit frame (payloads 0x5A/0x1A5) -> two FrameErr pulses, no DataValid, LedOut holds its prior value.
REQ-033 SCLK toggling 8 times with CSIn high and DINex = 1 -> LedOut, DataValid and Busy unchanged.
REQ-034 CLRIn low after bit 4 of a frame with LedOut = 0x35 -> LedOut = 0 and Busy = 0; completing the frame while CLRIn is still high-released with CSIn held low produces no pulse.
REQ-035 SysRst asserted after bit 5 of a frame -> outputs immediately at reset values; after release, the remaining bits and the CSIn rise produce no DataValid and no FrameErr.
